// File: rtl/stream_cipher_buf_if.sv
// Valid/ready stream bundle for stream_cipher_buf: input word + mode, result word.
interface stream_cipher_buf_if #(
  parameter int WIDTH = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_cipher_buf.sv
// Chained XOR stream cipher with a circular ciphertext history buffer.
// Results stream out through valid/ready; any stored entry can be read back.
module stream_cipher_buf #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] IV        = '0,
  parameter bit               OVERWRITE = 1'b1,
  localparam int              AW        = $clog2(DEPTH),
  localparam int              CW        = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  stream_cipher_buf_if.slave bus,
  input  logic [AW-1:0]    rd_idx_i,
  input  logic             rd_view_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic             full_w;
  logic             accept_w;
  logic [WIDTH-1:0] cipher_w;

  assign full_w   = (count_q == CW'(DEPTH));
  assign bus.in_ready = !rst && !clr_i && (!out_valid_q || bus.out_ready)
                        && (!full_w || OVERWRITE);
  assign accept_w = bus.in_valid && bus.in_ready;
  // The buffer always holds ciphertext, whichever direction the word travels.
  assign cipher_w = bus.mode ? bus.in_data : (bus.in_data ^ prev_q);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prev_d      = prev_q;
    base_d      = base_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept_w) begin
      prev_d      = cipher_w;
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data ^ prev_q;
      wr_ptr_d    = wr_ptr_q + AW'(1);
      if (full_w) begin
        // Evicted entry becomes the chain seed for the new oldest entry.
        base_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        count_d  = count_q + CW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  logic [AW-1:0]    e_idx_w, p_idx_w;
  logic [WIDTH-1:0] e_w, chain_w;

  always_comb begin
    e_idx_w   = rd_ptr_q + rd_idx_i;
    p_idx_w   = e_idx_w - AW'(1);
    e_w       = mem_q[e_idx_w];
    chain_w   = (rd_idx_i == '0) ? base_q : mem_q[p_idx_w];
    rd_data_d = '0;
    if ({1'b0, rd_idx_i} < count_q)
      rd_data_d = rd_view_i ? e_w : (e_w ^ chain_w);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prev_q      <= IV;
      base_q      <= IV;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_data_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prev_q      <= IV;
      base_q      <= IV;
      out_valid_q <= 1'b0;
      rd_data_q   <= rd_data_d;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prev_q      <= prev_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale
  // contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (accept_w) mem_q[wr_ptr_q] <= cipher_w;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign rd_data_o     = rd_data_q;
  assign count_o       = count_q;
  assign full_o        = full_w;
  assign empty_o       = (count_q == '0);

endmodule
